// File: rtl/sap_pkg.sv
// Shared SAP definitions: control word bit positions, opcodes and loader states.
package sap_pkg;

    localparam int unsigned CW_HLT       = 11;
    localparam int unsigned CW_PC_INC    = 10;
    localparam int unsigned CW_PC_EN     = 9;
    localparam int unsigned CW_MEM_LOAD  = 8;
    localparam int unsigned CW_MEM_EN    = 7;
    localparam int unsigned CW_IR_LOAD   = 6;
    localparam int unsigned CW_IR_EN     = 5;
    localparam int unsigned CW_A_LOAD    = 4;
    localparam int unsigned CW_A_EN      = 3;
    localparam int unsigned CW_B_LOAD    = 2;
    localparam int unsigned CW_ADDER_SUB = 1;
    localparam int unsigned CW_ADDER_EN  = 0;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun
    } load_state_e;

endpackage

// File: rtl/sap_memory_unit_if.sv
// Sequencer/bus and program-loader signals of the SAP memory stage.
interface sap_memory_unit_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
);
    logic              mem_load;
    logic              mem_en;
    logic              hlt;
    logic [DATA_W-1:0] bus_in;
    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;
    logic              prog_start;
    logic              prog_valid;
    logic [DATA_W-1:0] prog_data;
    logic              prog_last;
    logic              prog_ready;
    logic              cpu_run;
    logic [ADDR_W:0]   load_count;

    modport master (
        output mem_load, mem_en, hlt, bus_in, prog_start, prog_valid, prog_data, prog_last,
        input  bus_out, bus_oe, prog_ready, cpu_run, load_count
    );

    modport slave (
        input  mem_load, mem_en, hlt, bus_in, prog_start, prog_valid, prog_data, prog_last,
        output bus_out, bus_oe, prog_ready, cpu_run, load_count
    );
endinterface

// File: rtl/sap_ram.sv
// Program/data RAM: synchronous write, asynchronous read, contents never reset.
module sap_ram #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sap_memory_unit.sv
// SAP memory stage: MAR, RAM and a sequential program loader that gates CPU execution.
module sap_memory_unit
    import sap_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input logic              clk,
    input logic              rst,
    sap_memory_unit_if.slave bus
);

    localparam logic [ADDR_W-1:0] MaxAddr = '1;

    load_state_e       state_q;
    logic [ADDR_W-1:0] mar_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W:0]   load_count_q;
    logic [DATA_W-1:0] rdata;
    logic              accept;
    logic              unused_bus_hi;

    // A word presented alongside a restart pulse is dropped.
    assign accept = (state_q == StLoad) && bus.prog_valid && !bus.prog_start;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            mar_q        <= '0;
            wr_ptr_q     <= '0;
            load_count_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.prog_start) begin
                        state_q      <= StLoad;
                        wr_ptr_q     <= '0;
                        load_count_q <= '0;
                    end
                end
                StLoad: begin
                    if (bus.prog_start) begin
                        wr_ptr_q     <= '0;
                        load_count_q <= '0;
                    end else if (accept) begin
                        wr_ptr_q     <= wr_ptr_q + 1'b1;
                        load_count_q <= load_count_q + 1'b1;
                        if (bus.prog_last || (wr_ptr_q == MaxAddr)) begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    // Reload only from a halted CPU; it takes priority over a MAR load.
                    if (bus.prog_start && bus.hlt) begin
                        state_q      <= StLoad;
                        mar_q        <= '0;
                        wr_ptr_q     <= '0;
                        load_count_q <= '0;
                    end else if (bus.mem_load) begin
                        mar_q <= bus.bus_in[ADDR_W-1:0];
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    sap_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk  (clk),
        .we   (accept),
        .waddr(wr_ptr_q),
        .wdata(bus.prog_data),
        .raddr(mar_q),
        .rdata(rdata)
    );

    assign bus.prog_ready = (state_q == StLoad);
    assign bus.cpu_run    = (state_q == StRun);
    assign bus.load_count = load_count_q;
    assign bus.bus_oe     = (state_q == StRun) && bus.mem_en;
    assign bus.bus_out    = bus.bus_oe ? rdata : '0;

    assign unused_bus_hi = ^bus.bus_in[DATA_W-1:ADDR_W];

endmodule

// File: tb/tb_sap_memory_unit.sv
// Directed self-checking bench for sap_memory_unit.
module tb_sap_memory_unit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sap_memory_unit_if #(.ADDR_W(4), .DATA_W(8)) bus_if ();

    sap_memory_unit #(
        .ADDR_W(4),
        .DATA_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] data, input logic last);
        bus_if.prog_valid = 1'b1;
        bus_if.prog_data  = data;
        bus_if.prog_last  = last;
        tick();
        bus_if.prog_valid = 1'b0;
        bus_if.prog_last  = 1'b0;
    endtask

    task automatic set_mar(input logic [7:0] addr);
        bus_if.bus_in   = addr;
        bus_if.mem_load = 1'b1;
        tick();
        bus_if.mem_load = 1'b0;
    endtask

    task automatic reload();
        bus_if.hlt        = 1'b1;
        bus_if.prog_start = 1'b1;
        tick();
        bus_if.hlt        = 1'b0;
        bus_if.prog_start = 1'b0;
    endtask

    task automatic test_reset_load();
        logic [7:0] words [3];
        words[0] = 8'h1E;
        words[1] = 8'h2F;
        words[2] = 8'hF0;
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus_if.cpu_run, bus_if.prog_ready, bus_if.bus_oe} !== 3'b000 ||
            bus_if.bus_out !== 8'h00 || bus_if.load_count !== 5'd0) begin
            errors++;
            $display("FAIL reset: run/rdy/oe=%b%b%b out=%h cnt=%0d, want 000 00 0",
                     bus_if.cpu_run, bus_if.prog_ready, bus_if.bus_oe, bus_if.bus_out,
                     bus_if.load_count);
        end
        rst = 1'b1;
        bus_if.prog_start = 1'b1;
        tick();
        bus_if.prog_start = 1'b0;
        checks++;
        if (bus_if.prog_ready !== 1'b1 || bus_if.cpu_run !== 1'b0) begin
            errors++;
            $display("FAIL load_enter: rdy=%b run=%b, want 1 0", bus_if.prog_ready,
                     bus_if.cpu_run);
        end
        send_word(words[0], 1'b0);
        send_word(words[1], 1'b0);
        checks++;
        if (bus_if.load_count !== 5'd2 || bus_if.cpu_run !== 1'b0 ||
            bus_if.prog_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_mid: cnt=%0d run=%b rdy=%b, want 2 0 1", bus_if.load_count,
                     bus_if.cpu_run, bus_if.prog_ready);
        end
        send_word(words[2], 1'b1);
        checks++;
        if (bus_if.load_count !== 5'd3 || bus_if.cpu_run !== 1'b1 ||
            bus_if.prog_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_done: cnt=%0d run=%b rdy=%b, want 3 1 0", bus_if.load_count,
                     bus_if.cpu_run, bus_if.prog_ready);
        end
        for (int i = 0; i < 3; i++) begin
            set_mar(8'(i));
            bus_if.mem_en = 1'b1;
            #1;
            checks++;
            if (bus_if.bus_out !== words[i]) begin
                errors++;
                $display("FAIL ram_init[%0d]: got %h want %h", i, bus_if.bus_out, words[i]);
            end
            bus_if.mem_en = 1'b0;
        end
    endtask

    task automatic test_run_read();
        set_mar(8'h02);
        bus_if.mem_en = 1'b1;
        #1;
        checks++;
        if (bus_if.bus_oe !== 1'b1 || bus_if.bus_out !== 8'hF0) begin
            errors++;
            $display("FAIL run_read: oe=%b out=%h, want 1 f0", bus_if.bus_oe, bus_if.bus_out);
        end
        bus_if.mem_en = 1'b0;
        #1;
        checks++;
        if (bus_if.bus_oe !== 1'b0 || bus_if.bus_out !== 8'h00) begin
            errors++;
            $display("FAIL run_idle_bus: oe=%b out=%h, want 0 00", bus_if.bus_oe,
                     bus_if.bus_out);
        end
    endtask

    task automatic test_capacity();
        reload();
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 1) begin
                tick();
                checks++;
                if (bus_if.load_count !== 5'(i) || bus_if.prog_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stall[%0d]: cnt=%0d rdy=%b, want %0d 1", i,
                             bus_if.load_count, bus_if.prog_ready, i);
                end
            end
            if (i == 15) begin
                checks++;
                if (bus_if.cpu_run !== 1'b0) begin
                    errors++;
                    $display("FAIL cap_early: run=%b want 0", bus_if.cpu_run);
                end
            end
            send_word(8'h30 + 8'(i), 1'b0);
        end
        checks++;
        if (bus_if.cpu_run !== 1'b1 || bus_if.load_count !== 5'd16) begin
            errors++;
            $display("FAIL cap_full: run=%b cnt=%0d, want 1 16", bus_if.cpu_run,
                     bus_if.load_count);
        end
        send_word(8'h55, 1'b1);
        checks++;
        if (bus_if.prog_ready !== 1'b0 || bus_if.load_count !== 5'd16) begin
            errors++;
            $display("FAIL cap_ignore: rdy=%b cnt=%0d, want 0 16", bus_if.prog_ready,
                     bus_if.load_count);
        end
        set_mar(8'h0F);
        bus_if.mem_en = 1'b1;
        #1;
        checks++;
        if (bus_if.bus_out !== 8'h3F) begin
            errors++;
            $display("FAIL cap_last_word: got %h want 3f", bus_if.bus_out);
        end
        bus_if.mem_en = 1'b0;
    endtask

    task automatic test_reload();
        set_mar(8'h03);
        bus_if.prog_start = 1'b1;
        bus_if.hlt        = 1'b0;
        tick();
        bus_if.prog_start = 1'b0;
        bus_if.mem_en     = 1'b1;
        #1;
        checks++;
        if (bus_if.cpu_run !== 1'b1 || bus_if.load_count !== 5'd16 ||
            bus_if.bus_out !== 8'h33) begin
            errors++;
            $display("FAIL reload_nohlt: run=%b cnt=%0d out=%h, want 1 16 33", bus_if.cpu_run,
                     bus_if.load_count, bus_if.bus_out);
        end
        bus_if.mem_en = 1'b0;
        reload();
        checks++;
        if (bus_if.cpu_run !== 1'b0 || bus_if.load_count !== 5'd0 ||
            bus_if.prog_ready !== 1'b1) begin
            errors++;
            $display("FAIL reload_hlt: run=%b cnt=%0d rdy=%b, want 0 0 1", bus_if.cpu_run,
                     bus_if.load_count, bus_if.prog_ready);
        end
        send_word(8'h66, 1'b0);
        bus_if.prog_start = 1'b1;
        send_word(8'h99, 1'b1);
        bus_if.prog_start = 1'b0;
        checks++;
        if (bus_if.load_count !== 5'd0 || bus_if.prog_ready !== 1'b1) begin
            errors++;
            $display("FAIL restart_drop: cnt=%0d rdy=%b, want 0 1", bus_if.load_count,
                     bus_if.prog_ready);
        end
        send_word(8'h77, 1'b0);
        send_word(8'h88, 1'b1);
        checks++;
        if (bus_if.cpu_run !== 1'b1 || bus_if.load_count !== 5'd2) begin
            errors++;
            $display("FAIL reload_done: run=%b cnt=%0d, want 1 2", bus_if.cpu_run,
                     bus_if.load_count);
        end
        // MAR was cleared by the reload, so no mem_load is needed to read word 0.
        bus_if.mem_en = 1'b1;
        #1;
        checks++;
        if (bus_if.bus_out !== 8'h77) begin
            errors++;
            $display("FAIL reload_mar0: got %h want 77", bus_if.bus_out);
        end
        bus_if.mem_en = 1'b0;
        set_mar(8'h02);
        bus_if.mem_en = 1'b1;
        #1;
        checks++;
        if (bus_if.bus_out !== 8'h32) begin
            errors++;
            $display("FAIL reload_keep: got %h want 32", bus_if.bus_out);
        end
        bus_if.mem_en = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        reload();
        send_word(8'hC1, 1'b0);
        send_word(8'hC2, 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++;
        if (bus_if.load_count !== 5'd0 || bus_if.cpu_run !== 1'b0 ||
            bus_if.bus_oe !== 1'b0 || bus_if.prog_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: cnt=%0d run=%b oe=%b rdy=%b, want 0 0 0 0",
                     bus_if.load_count, bus_if.cpu_run, bus_if.bus_oe, bus_if.prog_ready);
        end
        bus_if.mem_en = 1'b1;
        tick();
        checks++;
        if (bus_if.bus_oe !== 1'b0 || bus_if.bus_out !== 8'h00) begin
            errors++;
            $display("FAIL idle_mem_en: oe=%b out=%h, want 0 00", bus_if.bus_oe,
                     bus_if.bus_out);
        end
        bus_if.mem_en     = 1'b0;
        bus_if.prog_start = 1'b1;
        tick();
        bus_if.prog_start = 1'b0;
        send_word(8'hD0, 1'b1);
        set_mar(8'h01);
        bus_if.mem_en = 1'b1;
        #1;
        checks++;
        if (bus_if.bus_out !== 8'hC2 || bus_if.load_count !== 5'd1) begin
            errors++;
            $display("FAIL rst_persist: out=%h cnt=%0d, want c2 1", bus_if.bus_out,
                     bus_if.load_count);
        end
        bus_if.mem_en = 1'b0;
    endtask

    task automatic test_load_and_read();
        set_mar(8'h01);
        bus_if.bus_in   = 8'h05;
        bus_if.mem_load = 1'b1;
        bus_if.mem_en   = 1'b1;
        #1;
        checks++;
        if (bus_if.bus_out !== 8'hC2) begin
            errors++;
            $display("FAIL both_old_mar: got %h want c2", bus_if.bus_out);
        end
        tick();
        bus_if.mem_load = 1'b0;
        #1;
        checks++;
        if (bus_if.bus_out !== 8'h35 || bus_if.bus_oe !== 1'b1) begin
            errors++;
            $display("FAIL both_new_mar: out=%h oe=%b, want 35 1", bus_if.bus_out,
                     bus_if.bus_oe);
        end
        bus_if.mem_en = 1'b0;
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        rst               = 1'b0;
        bus_if.mem_load   = 1'b0;
        bus_if.mem_en     = 1'b0;
        bus_if.hlt        = 1'b0;
        bus_if.bus_in     = 8'h00;
        bus_if.prog_start = 1'b0;
        bus_if.prog_valid = 1'b0;
        bus_if.prog_data  = 8'h00;
        bus_if.prog_last  = 1'b0;
        test_reset_load();
        test_run_read();
        test_capacity();
        test_reload();
        test_reset_mid_load();
        test_load_and_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sap_memory_unit.md
Name: sap_memory_unit

Overview:
- Memory stage of the SAP datapath. It consumes the memory-related control bits from the sequencer: MEM_LOAD loads the MAR, and MEM_EN drives the RAM word onto the bus.
- Contains the MAR, a 2^ADDR_W x DATA_W RAM, and a program loader with a valid/ready handshake that fills RAM sequentially from address 0.
- Gates CPU execution: the CPU runs only after a load completes.

Parameters:
- ADDR_W, 4, MAR and RAM address width (RAM depth = 2^ADDR_W).
- DATA_W, 8, bus and RAM word width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
- mem_load  in  1  control word bit MEM_LOAD: MAR <= bus_in[ADDR_W-1:0].
- mem_en  in  1  control word bit MEM_EN: drive ram[MAR] onto the bus.
- hlt  in  1  control word bit HLT from the sequencer.
- bus_in  in  DATA_W  current bus value from the other drivers.
- bus_out  out  DATA_W  RAM read data.
- bus_oe  out  1  bus drive enable.
- prog_start  in  1  pulse that begins a program load.
- prog_valid  in  1  loader word valid.
- prog_data  in  DATA_W  loader word.
- prog_last  in  1  marks the final word of the program.
- prog_ready  out  1  loader accepts a word this cycle.
- cpu_run  out  1  high = sequencer may run; low = hold the sequencer in reset.
- load_count  out  ADDR_W+1  number of words written by the last or current load.

Behaviour:
- Reset values (rst=0 at posedge):
  - MAR=0, state=IDLE, load_count=0, wr_ptr=0.
  - cpu_run=0, prog_ready=0, bus_oe=0, bus_out=0.
  - RAM contents are not cleared.
- States: IDLE, LOAD, RUN.
- IDLE:
  - cpu_run=0; control inputs are ignored.
  - prog_start=1 -> LOAD, with wr_ptr=0 and load_count=0.
- LOAD:
  - prog_ready=1.
  - A word is accepted when prog_valid & prog_ready. On acceptance:
    - ram[wr_ptr] <= prog_data
    - wr_ptr++
    - load_count++
  - Accepted word with prog_last=1 -> RUN on the next cycle.
  - Accepted word at wr_ptr = 2^ADDR_W-1 -> RUN regardless of prog_last (capacity reached; load_count = 2^ADDR_W).
  - prog_valid=0 -> hold; no timeout.
  - prog_start while in LOAD restarts the load (wr_ptr=0, load_count=0); any word presented that cycle is dropped.
- RUN:
  - cpu_run=1; prog_ready=0; the loader is ignored.
  - mem_load=1 -> MAR <= bus_in[ADDR_W-1:0] at posedge.
  - mem_en=1 -> bus_oe=1 and bus_out=ram[MAR]. This is a combinational read from the registered MAR, so data is valid in the same cycle.
  - mem_en=0 -> bus_oe=0 and bus_out=0.
  - mem_load and mem_en both high: bus_out uses the old MAR; MAR loads bus_in at the edge. No feedback from bus_out into bus_in inside the block.
  - Reload: prog_start is accepted only when hlt=1 -> LOAD, cpu_run falls the next cycle, MAR is cleared to 0. prog_start with hlt=0 is ignored.
- Outside RUN: bus_oe=0 and bus_out=0 regardless of mem_en. MAR is held, except on a reload.
- Reset mid-load: the load is abandoned, state=IDLE, load_count=0. Already-written RAM words persist.
- Timing: the sequencer changes its control word on negedge, so control inputs are stable at the posedge sample. No extra latency in this block.

Decomposition:
- Shared package sap_pkg:
  - control word bit indices (HLT..ADDER_EN, 11..0)
  - opcode constants (LDA=0000, ADD=0001, SUB=0010, HLT=1111)
  - loader state enum {IDLE, LOAD, RUN}
- Sub-module sap_ram:
  - parameterised ADDR_W/DATA_W
  - synchronous write port (we, waddr, wdata)
  - asynchronous read port (raddr, rdata)
- MAR, FSM and handshake live in sap_memory_unit.

Test Plan:
1. Reset then load: rst low 2 cycles, then high; prog_start; words 0x1E, 0x2F, 0xF0 with prog_last on the third -> prog_ready=1 during LOAD, load_count=3, cpu_run=1 one cycle after the last word; ram[0..2] match.
2. RUN read: bus_in=0x02 with mem_load -> MAR=2; then mem_en -> bus_oe=1, bus_out=0xF0 the same cycle; mem_en=0 -> bus_oe=0, bus_out=0.
3. Capacity and stalls: 16 words without prog_last, with prog_valid gaps -> no acceptance during gaps; after the 16th word state=RUN, load_count=16; further prog_valid is ignored (prog_ready=0).
4. Reload gating: in RUN, prog_start with hlt=0 -> no change; with hlt=1 -> cpu_run=0 the next cycle, MAR=0, new load overwrites from address 0.
5. Reset mid-load: after 2 accepted words assert rst -> IDLE, load_count=0, cpu_run=0, bus_oe=0; in IDLE, mem_en=1 -> bus_oe stays 0.
6. Simultaneous mem_load and mem_en: MAR=1, bus_in=0x05 -> bus_out=ram[1] that cycle; MAR=5 after the edge.
